// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width and ISA funct3 function codes.
package alu_pkg;
  localparam int DATA_W = 32;

  localparam logic [2:0] ADD_SUB = 3'b000;
  localparam logic [2:0] SLL     = 3'b001;
  localparam logic [2:0] SLT     = 3'b010;
  localparam logic [2:0] SLTU    = 3'b011;
  localparam logic [2:0] XOR     = 3'b100;
  localparam logic [2:0] SRL_SRA = 3'b101;
  localparam logic [2:0] OR      = 3'b110;
  localparam logic [2:0] AND     = 3'b111;
endpackage

// File: rtl/alu.sv
// Combinational integer ALU, funct3 select; func_sel picks SUB/SRA for ADD_SUB/SRL_SRA.
// Zero latency, no flow control.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_in1,
  input  logic [DATA_W-1:0] i_in2,
  input  logic [2:0]        i_func,
  input  logic              i_func_sel,
  output logic [DATA_W-1:0] o_result
);
  logic [4:0] w_shamt;

  assign w_shamt = i_in2[4:0];

  always_comb begin
    o_result = '0;
    case (i_func)
      ADD_SUB: o_result = i_func_sel ? (i_in1 - i_in2) : (i_in1 + i_in2);
      SLL:     o_result = i_in1 << w_shamt;
      SLT:     o_result = {{(DATA_W-1){1'b0}}, ($signed(i_in1) < $signed(i_in2))};
      SLTU:    o_result = {{(DATA_W-1){1'b0}}, (i_in1 < i_in2)};
      XOR:     o_result = i_in1 ^ i_in2;
      SRL_SRA: o_result = i_func_sel ? DATA_W'($signed(i_in1) >>> w_shamt) : (i_in1 >> w_shamt);
      OR:      o_result = i_in1 | i_in2;
      AND:     o_result = i_in1 & i_in2;
      default: o_result = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; 1-cycle latency into per-port response slots, a held slot blocks only its own port.
// Round-robin on conflict; define ALU_ARB_FIXED_PRIO_EN to make port 0 always win.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_in1,
  input  logic [DATA_W-1:0] req0_in2,
  input  logic [2:0]        req0_func,
  input  logic              req0_func_sel,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_in1,
  input  logic [DATA_W-1:0] req1_in2,
  input  logic [2:0]        req1_func,
  input  logic              req1_func_sel,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_data,
  output logic [TAG_W-1:0]  resp0_tag,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_data,
  output logic [TAG_W-1:0]  resp1_tag
);
  logic              r_last_grant;
  logic              r_resp0_valid;
  logic [DATA_W-1:0] r_resp0_data;
  logic [TAG_W-1:0]  r_resp0_tag;
  logic              r_resp1_valid;
  logic [DATA_W-1:0] r_resp1_data;
  logic [TAG_W-1:0]  r_resp1_tag;

  logic              w_elig0;
  logic              w_elig1;
  logic              w_prefer1;
  logic              w_grant0;
  logic              w_grant1;
  logic [DATA_W-1:0] w_alu_in1;
  logic [DATA_W-1:0] w_alu_in2;
  logic [2:0]        w_alu_func;
  logic              w_alu_sel;
  logic [DATA_W-1:0] w_alu_res;

  // A slot being drained this cycle can be refilled in the same cycle.
  assign w_elig0 = req0_valid && (!r_resp0_valid || resp0_ready);
  assign w_elig1 = req1_valid && (!r_resp1_valid || resp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_prefer1 = 1'b0;
`else
  assign w_prefer1 = (r_last_grant == 1'b0);
`endif

  assign w_grant0   = !reset && w_elig0 && !(w_elig1 && w_prefer1);
  assign w_grant1   = !reset && w_elig1 && !w_grant0;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  assign w_alu_in1  = w_grant1 ? req1_in1      : req0_in1;
  assign w_alu_in2  = w_grant1 ? req1_in2      : req0_in2;
  assign w_alu_func = w_grant1 ? req1_func     : req0_func;
  assign w_alu_sel  = w_grant1 ? req1_func_sel : req0_func_sel;

  alu u_alu (
    .i_in1      (w_alu_in1),
    .i_in2      (w_alu_in2),
    .i_func     (w_alu_func),
    .i_func_sel (w_alu_sel),
    .o_result   (w_alu_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant  <= 1'b1;
      r_resp0_valid <= 1'b0;
      r_resp0_data  <= '0;
      r_resp0_tag   <= '0;
      r_resp1_valid <= 1'b0;
      r_resp1_data  <= '0;
      r_resp1_tag   <= '0;
    end else begin
      if (w_grant0) begin
        r_resp0_valid <= 1'b1;
        r_resp0_data  <= w_alu_res;
        r_resp0_tag   <= req0_tag;
      end else if (resp0_ready) begin
        r_resp0_valid <= 1'b0;
      end
      if (w_grant1) begin
        r_resp1_valid <= 1'b1;
        r_resp1_data  <= w_alu_res;
        r_resp1_tag   <= req1_tag;
      end else if (resp1_ready) begin
        r_resp1_valid <= 1'b0;
      end
`ifndef ALU_ARB_FIXED_PRIO_EN
      if (w_grant0) begin
        r_last_grant <= 1'b0;
      end else if (w_grant1) begin
        r_last_grant <= 1'b1;
      end
`endif
    end
  end

  assign resp0_valid = r_resp0_valid;
  assign resp0_data  = r_resp0_data;
  assign resp0_tag   = r_resp0_tag;
  assign resp1_valid = r_resp1_valid;
  assign resp1_data  = r_resp1_data;
  assign resp1_tag   = r_resp1_tag;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed + random bench for alu_arbiter against a cycle-level reference model.
module tb_alu_arbiter;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req0_func_sel;
  logic [31:0]      req0_in1, req0_in2;
  logic [2:0]       req0_func;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready, req1_func_sel;
  logic [31:0]      req1_in1, req1_in2;
  logic [2:0]       req1_func;
  logic [TAG_W-1:0] req1_tag;
  logic             resp0_valid, resp0_ready;
  logic [31:0]      resp0_data;
  logic [TAG_W-1:0] resp0_tag;
  logic             resp1_valid, resp1_ready;
  logic [31:0]      resp1_data;
  logic [TAG_W-1:0] resp1_tag;

  int checks = 0;
  int errors = 0;

  // Reference state: what each response slot should hold, and who won last.
  logic             m_vld [2];
  logic [31:0]      m_dat [2];
  logic [TAG_W-1:0] m_tag [2];
  int               m_last;
  logic             g0_seen, g1_seen;

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req0_func(req0_func), .req0_func_sel(req0_func_sel), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2),
    .req1_func(req1_func), .req1_func_sel(req1_func_sel), .req1_tag(req1_tag),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_tag(resp0_tag),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_tag(resp1_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic sel,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint sa;
    sh = b % 32;
    sa = longint'($signed(a));
    case (f)
      3'd0: return sel ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (sa < longint'($signed(b))) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return sel ? 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0))
                       : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_vld[n] = 1'b0;
      m_dat[n] = '0;
      m_tag[n] = '0;
    end
    m_last = 1;
  endtask

  // One clock: check grants mid-cycle, advance the model at the edge, check slots after it.
  task automatic cycle();
    logic e0, e1;
    int   winner;
    @(negedge clk);
    e0 = req0_valid && (!m_vld[0] || resp0_ready);
    e1 = req1_valid && (!m_vld[1] || resp1_ready);
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (e0 && e1) winner = 0;
`else
    if (e0 && e1) winner = 1 - m_last;
`endif
    else if (e0) winner = 0;
    else if (e1) winner = 1;
    else winner = -1;
    g0_seen = req0_ready;
    g1_seen = req1_ready;
    chk("req0_ready", 32'(req0_ready), 32'(winner == 0));
    chk("req1_ready", 32'(req1_ready), 32'(winner == 1));
    @(posedge clk);
    if (winner == 0) begin
      m_vld[0] = 1'b1;
      m_dat[0] = ref_alu(req0_func, req0_func_sel, req0_in1, req0_in2);
      m_tag[0] = req0_tag;
    end else if (resp0_ready) m_vld[0] = 1'b0;
    if (winner == 1) begin
      m_vld[1] = 1'b1;
      m_dat[1] = ref_alu(req1_func, req1_func_sel, req1_in1, req1_in2);
      m_tag[1] = req1_tag;
    end else if (resp1_ready) m_vld[1] = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    if (winner >= 0) m_last = winner;
`endif
    #1;
    chk("resp0_valid", 32'(resp0_valid), 32'(m_vld[0]));
    chk("resp0_data",  resp0_data,        m_dat[0]);
    chk("resp0_tag",   32'(resp0_tag),    32'(m_tag[0]));
    chk("resp1_valid", 32'(resp1_valid), 32'(m_vld[1]));
    chk("resp1_data",  resp1_data,        m_dat[1]);
    chk("resp1_tag",   32'(resp1_tag),    32'(m_tag[1]));
  endtask

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input logic s, input logic [TAG_W-1:0] t);
    req0_valid = v; req0_in1 = a; req0_in2 = b; req0_func = f; req0_func_sel = s; req0_tag = t;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input logic s, input logic [TAG_W-1:0] t);
    req1_valid = v; req1_in1 = a; req1_in2 = b; req1_func = f; req1_func_sel = s; req1_tag = t;
  endtask

  initial begin
    reset = 1'b1;
    set_req0(1'b1, 0, 0, 3'd0, 1'b0, 0);
    set_req1(1'b1, 0, 0, 3'd0, 1'b0, 0);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    model_reset();
    g0_seen = 1'b0;
    g1_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_req1_ready", 32'(req1_ready), 0);
    chk("rst_resp0_valid", 32'(resp0_valid), 0);
    chk("rst_resp1_valid", 32'(resp1_valid), 0);
    chk("rst_resp0_data", resp0_data, 0);
    chk("rst_resp1_tag", 32'(resp1_tag), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;

    // Lone ADD on port 0, result held by a stalled consumer.
    set_req0(1'b1, 32'd5, 32'd3, 3'd0, 1'b0, 4'd2);
    cycle();
    chk("add_granted", 32'(g0_seen), 1);
    chk("add_valid", 32'(resp0_valid), 1);
    chk("add_data", resp0_data, 32'd8);
    chk("add_tag", 32'(resp0_tag), 32'd2);

    // Port 0 blocked by its own held slot; port 1 proceeds.
    set_req0(1'b1, 32'd1, 32'd1, 3'd0, 1'b0, 4'd3);
    set_req1(1'b1, 32'hF0, 32'h0F, 3'd4, 1'b0, 4'd5);
    resp1_ready = 1'b1;
    cycle();
    chk("block_req0_ready", 32'(g0_seen), 0);
    chk("block_req1_ready", 32'(g1_seen), 1);
    chk("block_resp0_held", resp0_data, 32'd8);
    chk("block_resp1_xor", resp1_data, 32'hFF);
    resp0_ready = 1'b1;
    req1_valid = 1'b0;
    cycle();
    chk("drain_refill_grant", 32'(g0_seen), 1);
    chk("refill_data", resp0_data, 32'd2);
    chk("refill_tag", 32'(resp0_tag), 32'd3);
    req0_valid = 1'b0;
    cycle();

    // Arithmetic vs logical right shift.
    set_req1(1'b1, 32'h8000_0000, 32'd4, 3'd5, 1'b1, 4'd9);
    cycle();
    chk("sra", resp1_data, 32'hF800_0000);
    req1_func_sel = 1'b0;
    cycle();
    chk("srl", resp1_data, 32'h0800_0000);
    req1_valid = 1'b0;
    resp1_ready = 1'b0;
    cycle();
    chk("held_before_reset", 32'(resp1_valid), 1);

    // Asynchronous reset mid-cycle with a held response.
    #2;
    req0_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("async_resp1_valid", 32'(resp1_valid), 0);
    chk("async_resp1_data", resp1_data, 0);
    chk("async_req0_ready", 32'(req0_ready), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_req0_ready", 32'(req0_ready), 0);
    chk("rst_hold_resp1_valid", 32'(resp1_valid), 0);
    model_reset();
    reset = 1'b0;

    // Continuous conflict, both consumers ready.
    set_req0(1'b1, 32'd10, 32'd3, 3'd0, 1'b1, 4'd1);
    set_req1(1'b1, 32'd1, 32'hFFFF_FFFF, 3'd3, 1'b0, 4'd6);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("fixed_grant0", 32'(g0_seen), 1);
      chk("fixed_grant1", 32'(g1_seen), 0);
`else
      chk("rr_grant0", 32'(g0_seen), 32'((i % 2) == 0));
      chk("rr_grant1", 32'(g1_seen), 32'((i % 2) == 1));
`endif
    end
    chk("conflict_sub", resp0_data, 32'd7);
`ifndef ALU_ARB_FIXED_PRIO_EN
    chk("conflict_sltu", resp1_data, 32'd1);
`endif

    // Random traffic; a pending request keeps its operands until granted.
    for (int i = 0; i < 400; i++) begin
      if (!(req0_valid && !g0_seen))
        set_req0(1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), TAG_W'($urandom));
      if (!(req1_valid && !g1_seen))
        set_req1(1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), TAG_W'($urandom));
      resp0_ready = 1'($urandom_range(0, 2) != 0);
      resp1_ready = 1'($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TAG_W, default 4, width of the requester tag passed through with each operation.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N in {0,1}) presents an operation.
REQ-005 reqN_ready  output  1  operation of requester N accepted this cycle.
REQ-006 reqN_in1, reqN_in2  input  32 each  ALU operands.
REQ-007 reqN_func  input  3  ALU function code, ISA funct3 encoding.
REQ-008 reqN_func_sel  input  1  SUB/SRA select, ISA funct7[5] meaning.
REQ-009 reqN_tag  input  TAG_W  opaque requester tag.
REQ-010 respN_valid  output  1  result for requester N is held.
REQ-011 respN_ready  input  1  requester N consumes the result.
REQ-012 respN_data  output  32  ALU result.
REQ-013 respN_tag  output  TAG_W  tag of the operation producing respN_data.

Function
REQ-014 Port N SHALL be eligible when reqN_valid && (!respN_valid || respN_ready).
REQ-015 At most one port SHALL be granted per cycle; reqN_ready = grant to N, combinational from valid/eligibility.
REQ-016 Single eligible port SHALL be granted; both eligible: port != last_grant wins (round-robin).
REQ-017 last_grant SHALL update only on a grant; no grant leaves it unchanged.
REQ-018 Granted operands SHALL drive the single shared ALU; result and tag registered into the granted port's response slot at the same edge, respN_valid=1 next cycle (latency 1).
REQ-019 respN_valid/data/tag SHALL hold stable while respN_valid && !respN_ready.
REQ-020 respN_valid SHALL clear on handshake unless a new grant to N occurs in the same cycle (refill; throughput 1 op/cycle/port).
REQ-021 Non-granted requester SHALL keep valid and operands asserted; the arbiter drops nothing.
REQ-022 func_sel SHALL pass unchanged; ignored by ALU for functions other than 000/101.
REQ-023 Round-robin: eligible waiting port SHALL be granted within 2 cycles.
REQ-024 Response slot of port N SHALL never be written unless granted to N.

Reset
REQ-025 On reset: respN_valid=0, respN_data=0, respN_tag=0, last_grant=1 (port 0 wins first conflict).
REQ-026 Reset mid-operation SHALL discard held responses immediately (async); reqN_ready=0 while reset asserted.

Configuration
REQ-027 Macro ALU_ARB_FIXED_PRIO_EN defined: port 0 SHALL win every conflict; last_grant held at reset value.
REQ-028 ALU_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-016/REQ-023.

Structure
REQ-029 Shared package alu_pkg SHALL hold ALU function-code constants (ADD_SUB..AND, 3-bit) and data width 32.
REQ-030 Exactly one sub-module instance: existing alu, shared by both ports via a grant mux.

Verification
REQ-031 req0 in1=5,in2=3,func=000,sel=0,tag=2 alone -> req0_ready=1, next cycle resp0_valid=1, data=8, tag=2.
REQ-032 Both valid continuously, resp ready=1; port0 SUB 10,3; port1 SLTU 1,0xFFFFFFFF -> grants 0,1,0,1; resp0_data=7, resp1_data=1.
REQ-033 resp0_ready=0 with resp0 held (data 8), req0 new op -> req0_ready=0, resp0 stable, req1 granted; resp0_ready=1 -> req0 accepted same cycle.
REQ-034 port1 in1=0x80000000,in2=4,func=101,sel=1 -> resp1_data=0xF8000000; sel=0 -> 0x08000000.
REQ-035 reset pulsed with resp1_valid=1 -> resp1_valid=0 without clock edge; first conflict after reset grants port 0.
REQ-036 ALU_ARB_FIXED_PRIO_EN defined, both valid 4 cycles, ready=1 -> port0 granted 4 times, req1_ready=0 throughout.
